// File: rtl/tdoa_collector.sv
// -----------------------------------------------------------------------------
// tdoa_collector
//
// Gathers one detection event from each of three microphone threshold
// detectors, acknowledges each channel as it is captured, and produces the two
// signed arrival-time differences (ch1 - ch0, ch2 - ch0) once a full set has
// been captured within WINDOW cycles of the first capture. Incomplete sets are
// discarded when the window expires, with a one-cycle timeout pulse.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active low (0 = reset)
//   det_valid  per-channel detection valid, held by the detector until acked
//   det_time   per-channel timestamp, channel k at [k*TW +: TW]
//   det_ack    per-channel one-cycle acknowledge (one cycle after capture)
//   diff_valid difference pair valid, held until diff_ack is sampled
//   diff10     det_time[1] - det_time[0], modulo 2^TW
//   diff20     det_time[2] - det_time[0], modulo 2^TW
//   diff_ack   consumer acknowledge
//   timeout    one-cycle pulse when an incomplete set is discarded
// -----------------------------------------------------------------------------
module tdoa_collector #(
   parameter int TW     = 32,
   parameter int WINDOW = 1000,
   parameter int CW     = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2:0]      det_valid,
   input  logic [3*TW-1:0] det_time,
   output logic [2:0]      det_ack,
   output logic            diff_valid,
   output logic [TW-1:0]   diff10,
   output logic [TW-1:0]   diff20,
   input  logic            diff_ack,
   output logic            timeout
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_OUTPUT  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      cap_q, cap_d;
   logic [2:0]      new_cap;
   logic [2:0]      ack_q, ack_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]   d10_q, d10_d;
   logic [TW-1:0]   d20_q, d20_d;
   logic            dv_q, dv_d;
   logic            to_q, to_d;
   logic            clr_times;
   logic [TW-1:0]   t_q [3];
   logic [TW-1:0]   t_d [3];

   // -------------------------------------------------------------------------
   // Per-channel timestamp storage. A channel's time is loaded on the cycle it
   // is captured and cleared when an incomplete set is discarded.
   // -------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         assign t_d[gi] = clr_times   ? '0 :
                          new_cap[gi] ? det_time[gi*TW +: TW] :
                                        t_q[gi];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               t_q[gi] <= '0;
            end else begin
               t_q[gi] <= t_d[gi];
            end
         end
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cap_d     = cap_q;
      new_cap   = 3'b000;
      ack_d     = 3'b000;
      cnt_d     = cnt_q;
      d10_d     = d10_q;
      d20_d     = d20_q;
      dv_d      = dv_q;
      to_d      = 1'b0;
      clr_times = 1'b0;

      case (state_q)
         S_IDLE: begin
            new_cap = det_valid & ~cap_q;
            ack_d   = new_cap;
            cap_d   = cap_q | new_cap;
            if (new_cap != 3'b000) begin
               cnt_d   = '0;
               state_d = (cap_d == 3'b111) ? S_OUTPUT : S_COLLECT;
            end
         end

         S_COLLECT: begin
            new_cap = det_valid & ~cap_q;
            ack_d   = new_cap;
            cap_d   = cap_q | new_cap;
            // A completing capture on the last window cycle wins over timeout.
            if (cap_d == 3'b111) begin
               state_d = S_OUTPUT;
            end else if (cnt_q == CW'(WINDOW)) begin
               to_d      = 1'b1;
               cap_d     = 3'b000;
               clr_times = 1'b1;
               cnt_d     = '0;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_OUTPUT: begin
            // First cycle in OUTPUT computes the pair; afterwards wait for the
            // consumer. diff_ack before diff_valid is up falls in the first
            // branch and is therefore ignored.
            if (!dv_q) begin
               d10_d = t_q[1] - t_q[0];
               d20_d = t_q[2] - t_q[0];
               dv_d  = 1'b1;
            end else if (diff_ack) begin
               dv_d    = 1'b0;
               cap_d   = 3'b000;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            cap_d   = 3'b000;
            dv_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cap_q   <= 3'b000;
         ack_q   <= 3'b000;
         cnt_q   <= '0;
         d10_q   <= '0;
         d20_q   <= '0;
         dv_q    <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         ack_q   <= ack_d;
         cnt_q   <= cnt_d;
         d10_q   <= d10_d;
         d20_q   <= d20_d;
         dv_q    <= dv_d;
         to_q    <= to_d;
      end
   end

   assign det_ack    = ack_q;
   assign diff_valid = dv_q;
   assign diff10     = d10_q;
   assign diff20     = d20_q;
   assign timeout    = to_q;

endmodule

// File: tb/tb_tdoa_collector.sv
// -----------------------------------------------------------------------------
// tb_tdoa_collector
//
// Directed bench for tdoa_collector. Two instances share the stimulus: one
// with the default window (1000) and one with WINDOW=8 for the window-expiry
// cases. sel chooses which instance's outputs are observed.
// -----------------------------------------------------------------------------
module tb_tdoa_collector;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  det_valid = 3'b000;
   logic [95:0] det_time  = '0;
   logic        diff_ack  = 1'b0;

   logic [2:0]  ack_a, ack_b;
   logic        dv_a, dv_b, to_a, to_b;
   logic [31:0] d10_a, d10_b, d20_a, d20_b;

   logic        sel = 1'b0;  // 0: WINDOW=1000 instance, 1: WINDOW=8 instance
   logic [2:0]  obs_ack;
   logic        obs_dv, obs_to;
   logic [31:0] obs_d10, obs_d20;

   logic [2:0]  drop_pend = 3'b000;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   tdoa_collector #(.TW(32), .WINDOW(1000), .CW(16)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .det_valid (det_valid),
      .det_time  (det_time),
      .det_ack   (ack_a),
      .diff_valid(dv_a),
      .diff10    (d10_a),
      .diff20    (d20_a),
      .diff_ack  (diff_ack),
      .timeout   (to_a)
   );

   tdoa_collector #(.TW(32), .WINDOW(8), .CW(16)) u_dut_w8 (
      .clk       (clk),
      .rst       (rst),
      .det_valid (det_valid),
      .det_time  (det_time),
      .det_ack   (ack_b),
      .diff_valid(dv_b),
      .diff10    (d10_b),
      .diff20    (d20_b),
      .diff_ack  (diff_ack),
      .timeout   (to_b)
   );

   assign obs_ack = sel ? ack_b : ack_a;
   assign obs_dv  = sel ? dv_b  : dv_a;
   assign obs_to  = sel ? to_b  : to_a;
   assign obs_d10 = sel ? d10_b : d10_a;
   assign obs_d20 = sel ? d20_b : d20_a;

   typedef struct {
      logic [31:0] t0;
      logic [31:0] t1;
      logic [31:0] t2;
      logic [31:0] e10;
      logic [31:0] e20;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One clock step. Detectors drop valid on the edge after seeing their ack,
   // so bits acked in the previous cycle are cleared here.
   task automatic tick();
      @(posedge clk);
      #1;
      det_valid = det_valid & ~drop_pend;
      drop_pend = obs_ack;
   endtask

   task automatic set_chan(input int k, input logic [31:0] t);
      det_valid[k]       = 1'b1;
      det_time[k*32 +: 32] = t;
   endtask

   task automatic do_reset();
      det_valid = 3'b000;
      diff_ack  = 1'b0;
      rst       = 1'b0;
      tick();
      tick();
      rst       = 1'b1;
      drop_pend = 3'b000;
   endtask

   initial begin
      int pulses;
      int dv_seen;
      int bad;

      vecs[0] = '{t0: 32'd100,        t1: 32'd90,         t2: 32'd140,        e10: 32'hFFFF_FFF6, e20: 32'd40};
      vecs[1] = '{t0: 32'hFFFF_FFFE,  t1: 32'h0000_0003,  t2: 32'hFFFF_FFFE,  e10: 32'd5,         e20: 32'd0};
      vecs[2] = '{t0: 32'd0,          t1: 32'd0,          t2: 32'd0,          e10: 32'd0,         e20: 32'd0};
      vecs[3] = '{t0: 32'd5,          t1: 32'd0,          t2: 32'd0,          e10: 32'hFFFF_FFFB, e20: 32'hFFFF_FFFB};
      vecs[4] = '{t0: 32'd0,          t1: 32'hFFFF_FFFF,  t2: 32'h8000_0000,  e10: 32'hFFFF_FFFF, e20: 32'h8000_0000};
      vecs[5] = '{t0: 32'd1234,       t1: 32'd5678,       t2: 32'd1000,       e10: 32'h0000_115C, e20: 32'hFFFF_FF16};

      // ---------------- Reset with all valids held ----------------
      sel = 1'b0;
      set_chan(0, 32'd10);
      set_chan(1, 32'd20);
      set_chan(2, 32'd40);
      rst = 1'b0;
      repeat (3) tick();
      check("rst_ack", {29'd0, obs_ack}, 32'd0);
      check("rst_dv", {31'd0, obs_dv}, 32'd0);
      check("rst_d10", obs_d10, 32'd0);
      check("rst_d20", obs_d20, 32'd0);
      check("rst_to", {31'd0, obs_to}, 32'd0);
      rst = 1'b1;
      tick();
      check("rel_ack", {29'd0, obs_ack}, 32'd7);
      check("rel_dv_early", {31'd0, obs_dv}, 32'd0);
      tick();
      check("rel_dv", {31'd0, obs_dv}, 32'd1);
      check("rel_d10", obs_d10, 32'd10);
      check("rel_d20", obs_d20, 32'd30);
      diff_ack = 1'b1;
      tick();
      diff_ack = 1'b0;
      check("rel_dv_drop", {31'd0, obs_dv}, 32'd0);
      $display("reset/release sequence done");

      // ---------------- Table: simultaneous full sets ----------------
      // diff_ack is held high throughout, so it is also present while
      // diff_valid is still low and must be ignored then.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set_chan(0, vecs[i].t0);
         set_chan(1, vecs[i].t1);
         set_chan(2, vecs[i].t2);
         diff_ack = 1'b1;
         tick();
         check("tab_ack", {29'd0, obs_ack}, 32'd7);
         check("tab_dv_early", {31'd0, obs_dv}, 32'd0);
         tick();
         check("tab_dv", {31'd0, obs_dv}, 32'd1);
         check("tab_d10", obs_d10, vecs[i].e10);
         check("tab_d20", obs_d20, vecs[i].e20);
         tick();
         check("tab_dv_drop", {31'd0, obs_dv}, 32'd0);
         check("tab_d10_hold", obs_d10, vecs[i].e10);
         check("tab_to", {31'd0, obs_to}, 32'd0);
         diff_ack = 1'b0;
         tick();
         $display("vector %0d t0=%08h t1=%08h t2=%08h d10=%08h d20=%08h",
                  i, vecs[i].t0, vecs[i].t1, vecs[i].t2, obs_d10, obs_d20);
      end

      // ---------------- Staggered arrival ----------------
      do_reset();
      set_chan(0, 32'd100);
      tick();                                   // edge 0
      check("stg_ack0", {29'd0, obs_ack}, 32'd1);
      bad = 0;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (obs_ack != 3'b000) bad++;
      end
      check("stg_no_reack_a", bad, 0);
      set_chan(2, 32'd140);
      tick();                                   // edge 5
      check("stg_ack2", {29'd0, obs_ack}, 32'd4);
      bad = 0;
      for (int c = 6; c <= 8; c++) begin
         tick();
         if (obs_ack != 3'b000 || obs_dv) bad++;
      end
      check("stg_no_reack_b", bad, 0);
      set_chan(1, 32'd90);
      tick();                                   // edge 9
      check("stg_ack1", {29'd0, obs_ack}, 32'd2);
      check("stg_dv_early", {31'd0, obs_dv}, 32'd0);
      tick();
      check("stg_dv", {31'd0, obs_dv}, 32'd1);
      check("stg_d10", obs_d10, 32'hFFFF_FFF6);
      check("stg_d20", obs_d20, 32'd40);
      bad = 0;
      for (int c = 0; c < 19; c++) begin
         tick();
         if (!obs_dv || obs_d10 != 32'hFFFF_FFF6 || obs_d20 != 32'd40) bad++;
      end
      check("stg_hold", bad, 0);
      diff_ack = 1'b1;
      tick();
      diff_ack = 1'b0;
      check("stg_dv_drop", {31'd0, obs_dv}, 32'd0);
      check("stg_d10_keep", obs_d10, 32'hFFFF_FFF6);
      $display("staggered sequence done");

      // ---------------- Timeout (WINDOW=8) ----------------
      sel = 1'b1;
      do_reset();
      set_chan(0, 32'd1);
      set_chan(1, 32'd2);
      tick();                                   // edge 0
      check("to_ack", {29'd0, obs_ack}, 32'd3);
      pulses  = 0;
      dv_seen = 0;
      for (int i = 1; i <= 14; i++) begin
         tick();
         if (i == 9) check("to_at_window", {31'd0, obs_to}, 32'd1);
         if (obs_to) pulses++;
         if (obs_dv) dv_seen++;
      end
      check("to_pulses", pulses, 1);
      check("to_no_dv", dv_seen, 0);
      set_chan(0, 32'd7);
      set_chan(1, 32'd3);
      set_chan(2, 32'd20);
      tick();
      check("to_after_ack", {29'd0, obs_ack}, 32'd7);
      tick();
      check("to_after_dv", {31'd0, obs_dv}, 32'd1);
      check("to_after_d10", obs_d10, 32'hFFFF_FFFC);
      check("to_after_d20", obs_d20, 32'd13);
      diff_ack = 1'b1;
      tick();
      diff_ack = 1'b0;
      $display("timeout sequence done");

      // ---------------- Window boundary (WINDOW=8) ----------------
      do_reset();
      set_chan(0, 32'd50);
      set_chan(1, 32'd55);
      tick();                                   // edge 0
      pulses = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (obs_to) pulses++;
      end
      set_chan(2, 32'd45);
      tick();                                   // edge 9: counter == WINDOW
      if (obs_to) pulses++;
      check("bnd_ack", {29'd0, obs_ack}, 32'd4);
      tick();
      if (obs_to) pulses++;
      check("bnd_no_to", pulses, 0);
      check("bnd_dv", {31'd0, obs_dv}, 32'd1);
      check("bnd_d10", obs_d10, 32'd5);
      check("bnd_d20", obs_d20, 32'hFFFF_FFFB);
      diff_ack = 1'b1;
      tick();
      diff_ack = 1'b0;
      $display("window boundary sequence done");

      // ---------------- Reset during COLLECT ----------------
      sel = 1'b0;
      do_reset();
      set_chan(0, 32'd50);
      set_chan(2, 32'd70);
      tick();                                   // edge 0
      check("mid_ack", {29'd0, obs_ack}, 32'd5);
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_ack", {29'd0, obs_ack}, 32'd0);
      check("mid_rst_dv", {31'd0, obs_dv}, 32'd0);
      check("mid_rst_to", {31'd0, obs_to}, 32'd0);
      drop_pend = 3'b000;
      tick();
      rst = 1'b1;
      tick();
      check("mid_reack", {29'd0, obs_ack}, 32'd5);
      set_chan(1, 32'd60);
      tick();
      check("mid_ack1", {29'd0, obs_ack}, 32'd2);
      tick();
      check("mid_dv", {31'd0, obs_dv}, 32'd1);
      check("mid_d10", obs_d10, 32'd10);
      check("mid_d20", obs_d20, 32'd20);
      diff_ack = 1'b1;
      tick();
      diff_ack = 1'b0;
      check("mid_dv_drop", {31'd0, obs_dv}, 32'd0);
      $display("reset-during-collect sequence done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
